demux_sequencer: RTL

DEMUX_SEQUENCER -- requirements
Module: demux_sequencer

---
 rtl/demux_sequencer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/demux_sequencer.sv
// Frame sequencer feeding a 1-to-4 demux: walks the enabled channels of a
// latched frame in ascending order, holding each one for HOLD cycles.
module demux_sequencer #(
  parameter int HOLD = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  input  logic [3:0] ch_mask,
  output logic       in_ready,
  output logic       i1,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DONE
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_data;
  logic [3:0] r_mask;
  logic [3:0] r_hold;
  logic [1:0] r_ch;

  logic       w_accept;
  logic       w_hold_end;
  logic       w_more;
  logic [1:0] w_first_ch;
  logic [1:0] w_next_ch;

  assign w_accept   = in_valid && (r_state == S_IDLE);
  assign w_hold_end = (r_hold == HOLD_LAST);

  // Lowest enabled channel of the incoming mask, and the next enabled
  // channel above the current one in the latched mask.
  always_comb begin
    w_first_ch = '0;
    w_next_ch  = '0;
    w_more     = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (ch_mask[k]) begin
        w_first_ch = 2'(k);
      end
      if (r_mask[k] && (k > int'(r_ch))) begin
        w_more    = 1'b1;
        w_next_ch = 2'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    sel      = 2'b00;
    i1       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (ch_mask != 4'b0000) begin
            w_next = S_DRIVE;
          end else begin
            w_next = S_DONE;
          end
        end
      end
      S_DRIVE: begin
        busy = 1'b1;
        sel  = r_ch;
        i1   = r_data[r_ch];
        if (w_hold_end && !w_more) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_mask <= '0;
      r_hold <= '0;
      r_ch   <= '0;
    end else if (w_accept) begin
      r_data <= in_data;
      r_mask <= ch_mask;
      r_hold <= '0;
      r_ch   <= w_first_ch;
    end else if (r_state == S_DRIVE) begin
      if (w_hold_end) begin
        r_hold <= '0;
        r_ch   <= w_next_ch;
      end else begin
        r_hold <= r_hold + 4'd1;
      end
    end
  end

endmodule
